// File: rtl/board_move_collector.sv
// board_move_collector
// Board-level reader for the eight column move FIFOs. Visits the columns in
// round-robin order. Each column is drained completely before the pointer
// moves on. Words go to the downstream consumer one at a time over a
// valid/ready handshake. The block counts delivered words and raises all_done
// once every column reports done with an empty FIFO.
// Optional feature: define MOVE_FILTER_INVALID_EN to drop words whose
// low-slot invalid flag (bit 18) is set instead of forwarding them.
module board_move_collector (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [7:0]     col_done,
   input  logic [7:0]     col_fifoEmpty,
   input  logic [1279:0]  col_fifoOut,
   output logic [7:0]     col_rden,
   output logic [159:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [9:0]     move_count,
   output logic           all_done
);

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      RD,
      HOLD,
      DONE
   } state_t;

   state_t         state;
   logic [2:0]     ptr;
   logic [159:0]   sel_word;
   logic           all_finished;

   assign all_finished = &(col_done & col_fifoEmpty);

   // Pick out the word presented by the column the pointer is on
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < 8; i++) begin
         if (ptr == 3'(i)) begin
            sel_word = col_fifoOut[i*160 +: 160];
         end
      end
   end

   // One-hot read strobe, only while selecting and only into a non-empty FIFO
   always_comb begin
      col_rden = '0;
      if (state == SEL && !col_fifoEmpty[ptr]) begin
         col_rden[ptr] = 1'b1;
      end
   end

   // Collection state machine with registered handshake, count and completion outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         move_count <= '0;
         all_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SEL;
                  ptr        <= '0;
                  move_count <= '0;
               end
            end
            SEL: begin
               if (!col_fifoEmpty[ptr]) begin
                  state <= RD;
               end else if (all_finished) begin
                  state    <= DONE;
                  all_done <= 1'b1;
               end else begin
                  ptr <= ptr + 3'd1;
               end
            end
            RD: begin
`ifdef MOVE_FILTER_INVALID_EN
               if (sel_word[18]) begin
                  state <= SEL;
               end else begin
                  out_data  <= sel_word;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
`else
               out_data  <= sel_word;
               out_valid <= 1'b1;
               state     <= HOLD;
`endif
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (move_count != 10'h3FF) begin
                     move_count <= move_count + 10'd1;
                  end
                  state <= SEL;
               end
            end
            DONE: begin
               if (start) begin
                  state      <= SEL;
                  ptr        <= '0;
                  move_count <= '0;
                  all_done   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_move_collector.sv
// tb_board_move_collector
// Bench for board_move_collector. Column FIFOs are modelled with one-cycle
// read latency. Every word expected at the output is queued when it is loaded
// and popped when the DUT hands it over.
`timescale 1ns/1ps
module tb_board_move_collector;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [7:0]     col_done;
   logic [7:0]     col_fifoEmpty;
   logic [1279:0]  col_fifoOut;
   logic [7:0]     col_rden;
   logic [159:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [9:0]     move_count;
   logic           all_done;

   int checks = 0;
   int fails  = 0;

   logic [159:0]   exp_q[$];

   logic [159:0]   mem[8][8];
   int             wr_cnt[8];
   int             rd_cnt[8];
   logic [159:0]   fifo_q[8];
   logic           fifo_clear;

   typedef struct {
      int         col;
      int         nwords;
      logic [7:0] done_mask;
      logic       exp_done;
      logic [9:0] exp_count;
   } vec_t;

   vec_t vecs[5];

   board_move_collector dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .col_done      (col_done),
      .col_fifoEmpty (col_fifoEmpty),
      .col_fifoOut   (col_fifoOut),
      .col_rden      (col_rden),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .move_count    (move_count),
      .all_done      (all_done)
   );

   always #5 clk = ~clk;

   // Column FIFO flags and data outputs
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         col_fifoEmpty[i]          = (rd_cnt[i] == wr_cnt[i]);
         col_fifoOut[i*160 +: 160] = fifo_q[i];
      end
   end

   // Column FIFO read port: data appears the cycle after the strobe
   always @(posedge clk) begin
      if (fifo_clear) begin
         for (int i = 0; i < 8; i++) rd_cnt[i] <= 0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (col_rden[i]) begin
               fifo_q[i] <= mem[i][rd_cnt[i] & 7];
               rd_cnt[i] <= rd_cnt[i] + 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard and read-strobe monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) checkOutput("unexpected word", 160'(1), 160'(0));
            else checkOutput("word order", out_data, exp_q.pop_front());
         end
         if (col_rden != 8'h00) begin
            checkOutput("rden onehot", 160'($onehot(col_rden)), 160'(1));
            checkOutput("rden to empty", 160'(|(col_rden & col_fifoEmpty)), 160'(0));
         end
      end
   end

   task automatic loadWord(input int col, input logic inv, input logic expect_out);
      logic [159:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      w[18] = inv;
      w[159:152] = 8'(col);
      w[151:144] = 8'(wr_cnt[col]);
      mem[col][wr_cnt[col] & 7] = w;
      wr_cnt[col] = wr_cnt[col] + 1;
      if (expect_out) exp_q.push_back(w);
   endtask

   task automatic applyStimulus(input int col, input int n);
      for (int k = 0; k < n; k++) loadWord(col, 1'b0, 1'b1);
   endtask

   task automatic resetDut();
      reset      = 1'b0;
      start      = 1'b0;
      out_ready  = 1'b0;
      col_done   = 8'h00;
      fifo_clear = 1'b1;
      for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      fifo_clear = 1'b0;
      reset      = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitAllDone(input int max);
      int n = 0;
      while (!all_done && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic waitOutValid(input int max);
      int n = 0;
      while (!out_valid && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("out_valid timeout", 160'(out_valid), 160'(1));
   endtask

   initial begin
      int n;

      vecs[0] = '{col: 0, nwords: 1, done_mask: 8'hFF, exp_done: 1'b1, exp_count: 10'd1};
      vecs[1] = '{col: 7, nwords: 4, done_mask: 8'hFF, exp_done: 1'b1, exp_count: 10'd4};
      vecs[2] = '{col: 3, nwords: 0, done_mask: 8'hFF, exp_done: 1'b1, exp_count: 10'd0};
      vecs[3] = '{col: 4, nwords: 2, done_mask: 8'hEF, exp_done: 1'b0, exp_count: 10'd2};
      vecs[4] = '{col: 1, nwords: 5, done_mask: 8'hFF, exp_done: 1'b1, exp_count: 10'd5};

      // Reset held with random inputs and a non-empty column 0
      reset      = 1'b0;
      fifo_clear = 1'b0;
      start      = 1'b0;
      out_ready  = 1'b0;
      col_done   = 8'h00;
      loadWord(0, 1'b0, 1'b1);
      for (int c = 0; c < 6; c++) begin
         start     = 1'($urandom);
         col_done  = 8'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk);
         #1;
         checkOutput("reset col_rden", 160'(col_rden), 160'(0));
         checkOutput("reset out_valid", 160'(out_valid), 160'(0));
         checkOutput("reset move_count", 160'(move_count), 160'(0));
         checkOutput("reset all_done", 160'(all_done), 160'(0));
         checkOutput("reset out_data", out_data, 160'(0));
      end
      start     = 1'b0;
      out_ready = 1'b0;
      col_done  = 8'hFF;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      pulseStart();
      checkOutput("first rden t1", 160'(col_rden), 160'(8'h01));
      @(posedge clk);
      #1;
      checkOutput("out_valid t2", 160'(out_valid), 160'(0));
      @(posedge clk);
      #1;
      checkOutput("out_valid t3", 160'(out_valid), 160'(1));
      out_ready = 1'b1;
      waitAllDone(30);
      checkOutput("first pass count", 160'(move_count), 160'(1));
      checkOutput("first pass done", 160'(all_done), 160'(1));

      // Table of single-column passes
      for (int v = 0; v < 5; v++) begin
         resetDut();
         applyStimulus(vecs[v].col, vecs[v].nwords);
         col_done  = vecs[v].done_mask;
         out_ready = 1'b1;
         pulseStart();
         waitAllDone(80);
         checkOutput("table all_done", 160'(all_done), 160'(vecs[v].exp_done));
         checkOutput("table move_count", 160'(move_count), 160'(vecs[v].exp_count));
         checkOutput("table drained", 160'(exp_q.size()), 160'(0));
      end

      // Round-robin across columns 2 and 5
      resetDut();
      applyStimulus(2, 3);
      applyStimulus(5, 3);
      col_done  = 8'hFF;
      out_ready = 1'b1;
      pulseStart();
      waitAllDone(200);
      checkOutput("rr move_count", 160'(move_count), 160'(6));
      checkOutput("rr all_done", 160'(all_done), 160'(1));
      checkOutput("rr drained", 160'(exp_q.size()), 160'(0));

      // Backpressure while holding a word
      resetDut();
      applyStimulus(0, 2);
      col_done = 8'hFF;
      pulseStart();
      waitOutValid(10);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) checkOutput("bp out_data", out_data, exp_q[0]);
         else checkOutput("bp queue", 160'(0), 160'(1));
         checkOutput("bp col_rden", 160'(col_rden), 160'(0));
         checkOutput("bp move_count", 160'(move_count), 160'(0));
         checkOutput("bp out_valid", 160'(out_valid), 160'(1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp accept count", 160'(move_count), 160'(1));
      waitAllDone(40);
      checkOutput("bp final count", 160'(move_count), 160'(2));

      // Late done on column 7
      resetDut();
      col_done  = 8'h7F;
      out_ready = 1'b1;
      pulseStart();
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (c % 5 == 4) checkOutput("late all_done low", 160'(all_done), 160'(0));
      end
      col_done = 8'hFF;
      n = 0;
      while (!all_done && n < 9) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("late all_done", 160'(all_done), 160'(1));

      // Invalid-flag filtering
      resetDut();
`ifdef MOVE_FILTER_INVALID_EN
      loadWord(0, 1'b1, 1'b0);
      loadWord(0, 1'b0, 1'b1);
      loadWord(0, 1'b1, 1'b0);
`else
      loadWord(0, 1'b1, 1'b1);
      loadWord(0, 1'b0, 1'b1);
      loadWord(0, 1'b1, 1'b1);
`endif
      col_done  = 8'hFF;
      out_ready = 1'b1;
      pulseStart();
      waitAllDone(60);
`ifdef MOVE_FILTER_INVALID_EN
      checkOutput("filter count", 160'(move_count), 160'(1));
`else
      checkOutput("filter count", 160'(move_count), 160'(3));
`endif
      checkOutput("filter drained", 160'(exp_q.size()), 160'(0));

      // Reset during HOLD, then a fresh pass
      resetDut();
      applyStimulus(0, 2);
      col_done = 8'hFF;
      pulseStart();
      waitOutValid(10);
      reset = 1'b0;
      #1;
      checkOutput("async out_valid", 160'(out_valid), 160'(0));
      checkOutput("async col_rden", 160'(col_rden), 160'(0));
      checkOutput("async out_data", out_data, 160'(0));
      exp_q.delete();
      exp_q.push_back(mem[0][1]);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      checkOutput("post reset out_valid", 160'(out_valid), 160'(0));
      out_ready = 1'b1;
      pulseStart();
      waitAllDone(40);
      checkOutput("restart count", 160'(move_count), 160'(1));
      checkOutput("restart all_done", 160'(all_done), 160'(1));
      checkOutput("restart drained", 160'(exp_q.size()), 160'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/board_move_collector.md
# board_move_collector

Board-level reader for the eight column move FIFOs. Drains each column's 160-bit move-word FIFO in round-robin order, presents one word at a time to the downstream move consumer over a valid/ready handshake, counts delivered words, and flags completion once every column is done and empty. Sits between the eight column units and the move-evaluation / host interface logic.

## Interface
- No parameters; column count fixed at 8, word width fixed at 160.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- start  in  1  one-cycle pulse; begins a collection pass (honoured in IDLE and DONE only)
- col_done  in  8  bit i = done output of column i
- col_fifoEmpty  in  8  bit i = fifoEmpty of column i
- col_fifoOut  in  1280  column i word on bits [160*i+159 : 160*i]
- col_rden  out  8  one-hot read enable to column i FIFO
- out_data  out  160  current move word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- move_count  out  10  words delivered this pass, saturates at 1023
- all_done  out  1  pass complete

## Operation
- Column FIFO read latency: word on col_fifoOut[i] is valid the cycle after col_rden[i]; fifoEmpty updates the cycle after the read.
- Word bit 18 is the invalid flag of the low move slot ([invalid][promote][pawn move][pawn 2 sq][en passant][castle][capture] in bits 18:12).
- States: IDLE, SEL, RD, HOLD, DONE; 3-bit round-robin pointer ptr.
- IDLE: outputs idle; start -> SEL, ptr=0, move_count=0.
- SEL: if col_fifoEmpty[ptr]=0: col_rden[ptr]=1 (combinational, this cycle only) -> RD. Else if &(col_done & col_fifoEmpty) -> DONE. Else ptr=ptr+1 (7 wraps to 0), stay SEL.
- RD: register col_fifoOut[ptr] into out_data, set out_valid -> HOLD.
- HOLD: out_valid=1, out_data stable; on out_ready: clear out_valid, move_count+1 (saturating), -> SEL with ptr unchanged (burst-drain same column until empty).
- DONE: all_done=1; start -> SEL, ptr=0, move_count=0, all_done=0. start outside IDLE/DONE ignored.
- col_rden never has more than one bit set; never asserted outside SEL; never asserted to an empty FIFO.
- Column done-but-nonempty: keep draining; completion requires empty on all 8.

## Timing
- Reset values: state IDLE, ptr 0, col_rden 0, out_data 0, out_valid 0, move_count 0, all_done 0.
- Read in SEL at cycle t; word captured end of t+1; out_valid high from t+2.
- With out_ready held high: one word per 3 cycles (SEL, RD, HOLD).
- Empty column skip: 1 cycle per column in SEL.
- all_done rises the cycle after the SEL evaluation that finds all columns done and empty.
- Reset asserted mid-pass: any captured or in-flight word discarded; no further col_rden; all outputs return to reset values asynchronously.
- out_ready while out_valid low: ignored.

## Configuration
- MOVE_FILTER_INVALID_EN defined: in RD, a word with bit 18 set is read and discarded—out_valid stays low, move_count unchanged, -> SEL directly.
- Undefined: every word forwarded regardless of bit 18.

## Test plan
- Reset: hold reset low with random inputs -> col_rden=0, out_valid=0, move_count=0, all_done=0; start at t=0 with col 0 holding 1 word -> col_rden=8'h01 at t=1, out_valid at t=3.
- Round-robin: columns 2 and 5 each 3 words, others empty, all done, out_ready=1 -> 3 words from col 2 then 3 from col 5 in FIFO order, move_count=6, all_done=1.
- Backpressure: out_ready low 10 cycles in HOLD -> out_data stable, no col_rden, count unchanged; out_ready high -> count +1.
- Late done: col 7 empty but col_done[7]=0 for 20 cycles -> all_done stays 0; raise col_done[7] -> all_done=1 within 9 cycles.
- Filter: words with bit 18 = 1,0,1 in col 0 -> MOVE_FILTER_INVALID_EN: 1 word out, count=1; undefined: 3 out, count=3.
- Reset mid-HOLD then start -> no stale word presented, move_count restarts at 0.
